// File: rtl/cla5_mp_seq.sv
// Multi-precision add/subtract sequencer: WORDS x 5-bit operands are pushed one
// slice per cycle (LSB first) through a single shared cla5 with a registered carry.

module cla5 (
    input  logic [4:0] A,
    input  logic [4:0] B,
    input  logic       Cin,
    output logic [4:0] S,
    output logic       Cout
);
    logic [4:0] g;
    logic [4:0] p;
    logic [5:0] c;

    // Fully expanded lookahead carries, no ripple between bit positions
    always_comb begin
        g    = A & B;
        p    = A ^ B;
        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & Cin);
        S    = p ^ c[4:0];
        Cout = c[5];
    end
endmodule

module cla5_mp_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5*WORDS-1:0]   op_a,
    input  logic [5*WORDS-1:0]   op_b,
    input  logic                 cin,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5*WORDS-1:0]   sum,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int unsigned W  = 5 * WORDS;
    localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [4:0]      a_sl, b_sl, s_sl;
    logic            co_sl;
    logic            last_c;

    // Select the active slice of each operand register
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[5*i +: 5];
                b_sl = b_q[5*i +: 5];
            end
        end
        last_c = (k_q == KW'(WORDS - 1));
    end

    cla5 u_cla (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry_q),
        .S    (s_sl),
        .Cout (co_sl)
    );

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub | cin;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (k_q == KW'(i)) sum_d[5*i +: 5] = s_sl;
                end
                carry_d = co_sl;
                k_d     = k_q + KW'(1);
                if (last_c) begin
                    cout_d      = co_sl;
                    // Top slice of a/b carries the operand sign bits
                    ovf_d       = (a_sl[4] == b_sl[4]) && (s_sl[4] != a_sl[4]);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Ready must drop the instant reset asserts and rise as soon as it releases
    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_cla5_mp_seq.sv
// Self-checking bench for cla5_mp_seq (WORDS=4): directed table, backpressure,
// asynchronous reset mid-operation and a randomized regression against an arithmetic model.

module tb_cla5_mp_seq;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 5 * WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    cla5_mp_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic         s;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected {ovf, cout, sum} from plain unsigned/signed integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        longint ua, ub, sa, sb, r, u;
        logic [W-1:0] rs;
        logic rc, ro;
        ua = longint'(a);
        ub = longint'(b);
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        if (s) begin
            u  = ua - ub;
            rs = W'(u);
            rc = (ua >= ub);
            r  = sa - sb;
        end else begin
            u  = ua + ub + longint'(c);
            rs = W'(u);
            rc = (u >= (longint'(1) << W));
            r  = sa + sb + longint'(c);
        end
        ro = (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
        return {ro, rc, rs};
    endfunction

    // Issue one command from IDLE, wait for the result, hold it for gap cycles, then consume
    task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input logic s, input int gap, output logic [W-1:0] rs,
                          output logic rc, output logic ro, output int lat);
        op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (gap) begin
            @(posedge clk); #1;
        end
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [W-1:0] rs;
    logic         rc, ro;
    int           lat;
    logic [W+1:0] exp;

    initial begin
        vecs[0] = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0};
        vecs[1] = '{20'd5,     20'd7,     1'b0, 1'b1, 20'hFFFFE, 1'b0, 1'b0};
        vecs[2] = '{20'd7,     20'd5,     1'b0, 1'b1, 20'd2,     1'b1, 1'b0};
        vecs[3] = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1};
        vecs[4] = '{20'h00000, 20'h00000, 1'b1, 1'b0, 20'h00001, 1'b0, 1'b0};
        vecs[5] = '{20'd7,     20'd5,     1'b1, 1'b1, 20'd2,     1'b1, 1'b0};
        vecs[6] = '{20'h80000, 20'h00001, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1};
        vecs[7] = '{20'h80000, 20'h80000, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'({ovf, cout, sum}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, i % 3, rs, rc, ro, lat);
            chk($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 64'(rc), 64'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_ovf", i), 64'(ro), 64'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(WORDS));
        end

        // Backpressure: result held while new commands are offered and refused
        op_a = 20'h0ABCD; op_b = 20'h01234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", 64'(lat), 64'(WORDS));
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom); sub = 1'b1;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_sum", 64'({cout, sum}), 64'({1'b0, 20'h0BE01}));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("bp_idle_sum_held", 64'(sum), 64'h0BE01);
        chk("bp_not_accepted", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of RUN (k=2)
        op_a = 20'h12345; op_b = 20'h11111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_run_busy", 64'(busy), 64'd1);
        #2; rst_n = 1'b0; #1;
        chk("async_rst_sum", 64'(sum), 64'd0);
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_in_ready", 64'(in_ready), 64'd1);
        chk("after_rst_out_valid", 64'(out_valid), 64'd0);
        do_cmd(20'd3, 20'd4, 1'b0, 1'b0, 0, rs, rc, ro, lat);
        chk("after_rst_sum", 64'({ro, rc, rs}), 64'd7);
        chk("after_rst_latency", 64'(lat), 64'(WORDS));

        // Randomized regression with random consumer gaps
        for (int n = 0; n < 2000; n++) begin
            logic [W-1:0] a, b;
            logic c, s;
            a = W'($urandom); b = W'($urandom);
            c = 1'($urandom); s = 1'($urandom);
            do_cmd(a, b, c, s, int'($urandom_range(0, 3)), rs, rc, ro, lat);
            exp = model(a, b, c, s);
            chk($sformatf("rand%0d_cout_sum a=%0h b=%0h c=%0d s=%0d", n, a, b, c, s),
                64'({rc, rs}), 64'(exp[W:0]));
            chk($sformatf("rand%0d_ovf", n), 64'(ro), 64'(exp[W+1]));
            chk($sformatf("rand%0d_latency", n), 64'(lat), 64'(WORDS));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cla5_mp_seq.md
Name: cla5_mp_seq

Overview:
Multi-precision add/subtract sequencer built around one cla5 instance (5-bit carry-lookahead adder; ports A, B, Cin, S, Cout). It accepts WORDS×5-bit operands on a valid/ready handshake. It feeds one 5-bit slice per cycle through the shared cla5, LSB slice first, with the carry chained through a register. The full-width result is returned on a valid/ready handshake. This gives wide arithmetic in the datapath without widening the adder.

Parameters:
WORDS, 4, number of 5-bit slices; operand width W = 5*WORDS (default 20); legal range 2..16.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/command valid
in_ready  output  1  block can accept a command (IDLE only)
op_a  input  W  operand A
op_b  input  W  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  result
cout  output  1  final carry out (sub: 1 = no borrow, A>=B unsigned)
ovf  output  1  two's-complement signed overflow of the W-bit operation
busy  output  1  high in RUN or DONE

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low immediately forces state IDLE. All of the following clear to 0: slice index, carry register, operand registers, sum, cout, ovf, out_valid and busy. in_ready=1 while rst_n is high in IDLE; in_ready=0 during reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture op_a into a_reg.
  - Capture op_b into b_reg, or ~op_b into b_reg when sub=1.
  - Set carry_reg = sub ? 1 : cin, and index k=0.
  - Go to RUN.
  - sum/cout/ovf keep their previous values until overwritten.
- RUN:
  - cla5 inputs are A=a_reg[5k+4:5k], B=b_reg[5k+4:5k], Cin=carry_reg; these are purely combinational from registers.
  - Each edge: sum[5k+4:5k] <= S, carry_reg <= Cout, k <= k+1.
  - On the edge processing k=WORDS-1:
    - cout <= Cout.
    - ovf <= (a_reg[W-1] == b_reg[W-1]) && (S[4] != a_reg[W-1]).
    - out_valid <= 1, go to DONE.
- Latency: command accepted at edge E0, slice k written at edge E0+k+1, out_valid high from edge E0+WORDS.
- DONE:
  - out_valid=1. sum/cout/ovf are held stable and in_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, go to IDLE.
  - Minimum command interval is WORDS+2 cycles.
- The operation completes with no stall possibility. Stalls occur only in DONE, through out_ready.
- in_valid is ignored outside IDLE; operand inputs are don't-care outside the accepting edge.
- out_ready is ignored outside DONE.
- busy = (state != IDLE).
- Width rules:
  - The result is modulo 2^W.
  - For sub, cout is the inverted borrow.
  - ovf uses the effective (possibly inverted) B.
- Reset mid-RUN or mid-DONE aborts the operation. No partial result is presented after reset.
- Illegal state encodings recover to IDLE.

Test Plan:
- WORDS=4, add A=20'hFFFFF, B=20'h00001, cin=0 -> checks:
  - carry ripples through all 4 slices.
  - sum=20'h00000, cout=1, ovf=0.
  - out_valid rises exactly 4 cycles after the accept edge.
- Subtract A=20'd5, B=20'd7, sub=1 -> sum=20'hFFFFE, cout=0, ovf=0. Subtract A=20'd7, B=20'd5 -> sum=20'd2, cout=1.
- Signed overflow, add A=20'h7FFFF, B=20'h00001 -> sum=20'h80000, cout=0, ovf=1. cin=1 with A=B=0 -> sum=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid with new operands. Required response:
  - out_valid stays 1, in_ready stays 0.
  - sum/cout are unchanged and the new command is not accepted.
  - After out_ready=1, in_ready returns next cycle.
- Reset: assert rst_n=0 asynchronously (mid-cycle) at k=2 of RUN. Required response:
  - Outputs clear immediately (sum=0, out_valid=0, busy=0).
  - After release, a fresh command A=3, B=4 yields sum=7 with normal latency.
- Random regression: 2000 random (op_a, op_b, cin, sub) commands with random out_ready gaps. Each result {cout,sum} matches A+B+cin, or A+~B+1 for sub, modulo 2^(W+1). Zero mismatches.
